pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the ARM datapath. It is the generalised successor of the fixed register-fetch/execute latch. It carries two data words plus a packed control bundle with a valid/ready handshake, an optional 2-entry skid buffer for full throughput under backpressure, a synchronous flush for branch/exception squash, and a saturating stall-cycle counter. One instance sits between each pair of pipeline stages (fetch/decode, decode/register-fetch, register-fetch/execute, execute/memory).

Parameters:
DATA_W, 32, width of each data word (in_data1/in_data2)
CTRL_W, 25, width of packed control bundle (layout fixed in shared package)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  squash all held entries and any same-cycle input
in_valid  in  1  upstream entry valid
in_ready  out  1  block can accept this cycle
in_data1  in  DATA_W  operand word 1
in_data2  in  DATA_W  operand word 2
in_ctrl  in  CTRL_W  packed control bundle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head this cycle
out_data1  out  DATA_W  head operand 1
out_data2  out  DATA_W  head operand 2
out_ctrl  out  CTRL_W  head control bundle
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Single clock clk. Reset is synchronous and active-high, named reset. All state updates on posedge clk.
- Handshakes: acc_in = in_valid & in_ready; acc_out = out_valid & out_ready.
- Reset (highest priority): state EMPTY, out_valid=0, out_data1/2=0, out_ctrl=0, skid regs=0, stall_cnt=0.
  - SKID=1: in_ready=1 after reset. While reset is high, inputs are ignored.
- Flush (second priority): state becomes EMPTY and out_valid becomes 0 next cycle. Any acc_in in the same cycle is dropped. Data regs hold their values (don't-care). stall_cnt is not cleared. With SKID=1, in_ready=1 next cycle.
- Latency: 1 cycle from acc_in to out_valid. Throughput: 1 entry/cycle sustained when out_ready=1.
- SKID=1 FSM (head = main reg, skid = second reg; in_ready is registered and equals (state != SKID_FULL)):
  - EMPTY: acc_in -> FULL, main<=in.
  - FULL: acc_in & acc_out -> FULL, main<=in. acc_in only -> SKID_FULL, skid<=in. acc_out only -> EMPTY. Neither -> hold.
  - SKID_FULL: in_ready=0, so acc_in cannot occur. acc_out -> FULL, main<=skid. Otherwise hold.
- SKID=0: states EMPTY/FULL only. in_ready = out_ready | ~out_valid (combinational). EMPTY/FULL transitions are as above, minus the skid path.
- Ordering: entries leave in strict arrival order. No duplication, no loss except by flush.
- Output stability: while out_valid=1 and out_ready=0, out_data1/2 and out_ctrl are held unchanged.
- stall_cnt: increments when out_valid & ~out_ready, saturates at 2^CNT_W-1, and does not wrap.
- No combinational path from in_* to out_* in either mode.

Decomposition:
- Shared package pipe_pkg holds the following, used by decoder and all stages:
  - field widths: OPCODE_W=5, COND_W=4, REGADDR_W=4.
  - CTRL_W=25.
  - control-bundle bit offsets: cond[24:21], opcode[20:16], rd[15:12], rm[11:8], link[7], prePost[6], upDown[5], byteWord[4], writeBack[3], loadStore[2], cpsrWrite[1], immOperand[0].
  - FSM state encodings EMPTY/FULL/SKID_FULL.
- One sub-module, pipe_stage_slot: a (2*DATA_W+CTRL_W)-bit register with load enable and synchronous reset-to-zero. It is instantiated as main and (when SKID=1) skid.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 and in_data1=0xDEADBEEF -> out_valid=0, out_data1=0, stall_cnt=0, in_ready=1 after reset.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, data1=0..7 -> out_data1 shows 0..7 on consecutive cycles starting 1 cycle after the first accept, with no bubbles.
- Backpressure (SKID=1): send 0xA, 0xB, 0xC with out_ready=0 -> 0xA and 0xB accepted, in_ready=0 on the 3rd cycle, out_data1=0xA held. Release out_ready -> outputs 0xA, 0xB, 0xC in order, and stall_cnt equals the number of stalled cycles.
- Flush: with SKID_FULL holding 0x1 and 0x2, assert flush with in_valid=1 and data 0x3 -> next cycle out_valid=0 and in_ready=1, and 0x3 never appears at the output.
- SKID=0 mode: out_ready=0 with one entry held -> in_ready=0 combinationally. Raise out_ready -> in_ready=1 in the same cycle, and simultaneous accept/dequeue keeps FULL.
- Counter saturation: CNT_W=4 with out_valid held and out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, field widths and the
// occupancy state encoding used by every inter-stage register.
package pipe_pkg;

    localparam int OPCODE_W  = 5;
    localparam int COND_W    = 4;
    localparam int REGADDR_W = 4;
    localparam int CTRL_W    = 25;

    localparam int CTRL_COND_LSB   = 21;
    localparam int CTRL_OPCODE_LSB = 16;
    localparam int CTRL_RD_LSB     = 12;
    localparam int CTRL_RM_LSB     = 8;
    localparam int CTRL_LINK       = 7;
    localparam int CTRL_PRE_POST   = 6;
    localparam int CTRL_UP_DOWN    = 5;
    localparam int CTRL_BYTE_WORD  = 4;
    localparam int CTRL_WRITE_BACK = 3;
    localparam int CTRL_LOAD_STORE = 2;
    localparam int CTRL_CPSR_WRITE = 1;
    localparam int CTRL_IMM_OP     = 0;

    // Field order matches the bit offsets above, msb first.
    typedef struct packed {
        logic [COND_W-1:0]    cond;
        logic [OPCODE_W-1:0]  opcode;
        logic [REGADDR_W-1:0] rd;
        logic [REGADDR_W-1:0] rm;
        logic                 link;
        logic                 pre_post;
        logic                 up_down;
        logic                 byte_word;
        logic                 write_back;
        logic                 load_store;
        logic                 cpsr_write;
        logic                 imm_operand;
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } stage_state_t;

    function automatic int slot_width(input int data_w, input int ctrl_w);
        return 2 * data_w + ctrl_w;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: two data words plus control bundle, loaded on demand,
// cleared by synchronous reset.
module pipe_stage_slot #(
    parameter int W = 89
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
//
// state     | meaning
// EMPTY     | no entry held, out_valid=0
// FULL      | head entry in main slot, out_valid=1
// SKID_FULL | head in main, next entry in skid slot, in_ready=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 25,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int SLOT_W = slot_width(DATA_W, CTRL_W);

    stage_state_t      state;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              acc_in;
    logic              acc_out;
    logic              main_load;
    logic              skid_load;
    logic [SLOT_W-1:0] in_word;
    logic [SLOT_W-1:0] main_d;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;

    assign in_word   = {in_data1, in_data2, in_ctrl};
    assign out_valid = out_valid_r;
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = out_valid_r & out_ready;
    assign {out_data1, out_data2, out_ctrl} = main_q;

    generate
        if (SKID != 0) begin : g_ready_reg
            assign in_ready = in_ready_r;
        end else begin : g_ready_comb
            assign in_ready = out_ready | ~out_valid_r;
        end
    endgenerate

    // Slot load enables; flush suppresses every load so a squashed input never lands.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_word;
        if (!flush) begin
            case (state)
                EMPTY: main_load = acc_in;
                FULL: begin
                    main_load = acc_in & acc_out;
                    skid_load = (SKID != 0) & acc_in & ~acc_out;
                end
                SKID_FULL: begin
                    main_load = acc_out;
                    main_d    = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_in) begin
                        state       <= FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                FULL: begin
                    if (acc_in && !acc_out && SKID != 0) begin
                        state      <= SKID_FULL;
                        in_ready_r <= 1'b0;
                    end else if (!acc_in && acc_out) begin
                        state       <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                SKID_FULL: begin
                    if (acc_out) begin
                        state      <= FULL;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    pipe_stage_slot #(.W(SLOT_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_slot #(.W(SLOT_W)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .d     (in_word),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid_r && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, no-skid and narrow-counter instances
// share stimulus; each phase checks the instance it targets.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid;
    logic [31:0] in_data1, in_data2;
    logic [24:0] in_ctrl;
    logic        or_a, or_b, or_c;

    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [31:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c;
    logic [24:0] c_a, c_b, c_c;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(25), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .in_data1(in_data1), .in_data2(in_data2), .in_ctrl(in_ctrl),
        .out_valid(ov_a), .out_ready(or_a), .out_data1(d1_a), .out_data2(d2_a),
        .out_ctrl(c_a), .stall_cnt(sc_a));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(25), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .in_data1(in_data1), .in_data2(in_data2), .in_ctrl(in_ctrl),
        .out_valid(ov_b), .out_ready(or_b), .out_data1(d1_b), .out_data2(d2_b),
        .out_ctrl(c_b), .stall_cnt(sc_b));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(25), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
        .in_data1(in_data1), .in_data2(in_data2), .in_ctrl(in_ctrl),
        .out_valid(ov_c), .out_ready(or_c), .out_data1(d1_c), .out_data2(d2_c),
        .out_ctrl(c_c), .stall_cnt(sc_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_data1 = 32'hDEADBEEF; in_data2 = 32'h0; in_ctrl = '0;
        or_a = 1'b0; or_b = 1'b0; or_c = 1'b0;

        // reset held two cycles with live input
        tick(); tick();
        chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_out_data1", d1_a, 32'd0);
        chk("rst_stall_cnt", {16'd0, sc_a}, 32'd0);
        chk("rst_in_ready", {31'd0, ir_a}, 32'd1);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, ir_a}, 32'd1);
        chk("post_rst_out_valid", {31'd0, ov_a}, 32'd0);

        // streaming, no bubbles
        or_a = 1'b1; or_b = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data1 = i; in_data2 = ~i; in_ctrl = 25'h1000000 | i;
            tick();
            chk($sformatf("stream_valid_%0d", i), {31'd0, ov_a}, 32'd1);
            chk($sformatf("stream_d1_%0d", i), d1_a, i);
            chk($sformatf("stream_ready_%0d", i), {31'd0, ir_a}, 32'd1);
            chk($sformatf("stream_ns_d1_%0d", i), d1_b, i);
        end
        chk("stream_d2", d2_a, 32'hFFFFFFF8);
        chk("stream_ctrl", {7'd0, c_a}, 32'h01000007);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'd0, ov_a}, 32'd0);
        chk("stream_ns_drain", {31'd0, ov_b}, 32'd0);

        // backpressure into skid entry
        or_a = 1'b0; in_valid = 1'b1; in_data1 = 32'hA;
        tick();
        chk("bp_d1_a", d1_a, 32'hA);
        chk("bp_ready1", {31'd0, ir_a}, 32'd1);
        in_data1 = 32'hB;
        tick();
        chk("bp_ready2", {31'd0, ir_a}, 32'd0);
        chk("bp_hold_a", d1_a, 32'hA);
        in_data1 = 32'hC;
        tick();
        chk("bp_ready3", {31'd0, ir_a}, 32'd0);
        chk("bp_hold_a2", d1_a, 32'hA);
        chk("bp_stall2", {16'd0, sc_a}, 32'd2);
        or_a = 1'b1;
        tick();
        chk("bp_out_b", d1_a, 32'hB);
        chk("bp_ready4", {31'd0, ir_a}, 32'd1);
        tick();
        chk("bp_out_c", d1_a, 32'hC);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", {31'd0, ov_a}, 32'd0);
        chk("bp_stall_final", {16'd0, sc_a}, 32'd2);

        // flush from SKID_FULL with input offered
        or_a = 1'b0; in_valid = 1'b1; in_data1 = 32'h1;
        tick();
        in_data1 = 32'h2;
        tick();
        chk("fl_skid_full", {31'd0, ir_a}, 32'd0);
        flush = 1'b1; in_data1 = 32'h3;
        tick();
        chk("fl_valid", {31'd0, ov_a}, 32'd0);
        chk("fl_ready", {31'd0, ir_a}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; or_a = 1'b1;
        tick();
        chk("fl_no_3", {31'd0, ov_a}, 32'd0);
        // flush from FULL drops a same-cycle accept
        in_valid = 1'b1; in_data1 = 32'h4;
        tick();
        chk("fl_full_d1", d1_a, 32'h4);
        flush = 1'b1; in_data1 = 32'h5; or_a = 1'b0;
        tick();
        chk("fl_drop_valid", {31'd0, ov_a}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_drop_still", {31'd0, ov_a}, 32'd0);
        chk("fl_stall_kept", {16'd0, sc_a}, 32'd5);

        reset = 1'b1;
        tick();
        chk("rst2_stall_clear", {16'd0, sc_a}, 32'd0);
        reset = 1'b0;

        // combinational ready without skid
        or_b = 1'b0; in_valid = 1'b1; in_data1 = 32'h11;
        #1;
        chk("ns_ready_empty", {31'd0, ir_b}, 32'd1);
        tick();
        chk("ns_valid", {31'd0, ov_b}, 32'd1);
        chk("ns_d1", d1_b, 32'h11);
        chk("ns_ready_stalled", {31'd0, ir_b}, 32'd0);
        in_data1 = 32'h99;
        tick();
        chk("ns_hold", d1_b, 32'h11);
        or_b = 1'b1;
        #1;
        chk("ns_ready_comb", {31'd0, ir_b}, 32'd1);
        in_data1 = 32'h22;
        tick();
        chk("ns_full_kept", {31'd0, ov_b}, 32'd1);
        chk("ns_d1_next", d1_b, 32'h22);
        in_valid = 1'b0;
        tick();
        chk("ns_drain", {31'd0, ov_b}, 32'd0);

        // counter saturation on the 4-bit instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        or_c = 1'b0; in_valid = 1'b1; in_data1 = 32'h5;
        tick();
        in_valid = 1'b0;
        chk("sat_start", {28'd0, sc_c}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) chk("sat_14", {28'd0, sc_c}, 32'd14);
            if (k == 15) chk("sat_15", {28'd0, sc_c}, 32'd15);
        end
        chk("sat_20", {28'd0, sc_c}, 32'd15);
        chk("sat_hold_d1", d1_c, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
